im_reader: RTL and testbench

Streaming read engine on the image memory's read port, directly downstream of the bus-to-memory write DMA stage. After a software-triggered start, it reads a contiguous run of 32-bit words from the 15-bit word-addressed image memory. Read data (one-cycle latency) passes through a small credit-controlled FIFO and leaves on a valid/ready stream to the next processing stage. The engine sustains one word per cycle when the consumer never stalls.

---
 rtl/im_reader_if.sv | 40 ++++
 rtl/im_reader.sv | 155 +++++++++++++++
 tb/tb_im_reader.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/im_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : im_reader_if
// Description : Image-memory read port plus output valid/ready stream of the
//               im_reader engine. master = engine side, slave = memory/consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface im_reader_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_rden;
    logic [DATA_W-1:0] mem_q;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport master (
        output mem_address,
        output mem_rden,
        input  mem_q,
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  mem_address,
        input  mem_rden,
        output mem_q,
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/im_reader.sv
`default_nettype none
// ============================================================================
// Module      : im_reader
// Description : Streaming image-memory read engine with credit-controlled
//               output FIFO. Optional frame replay built with IM_READER_LOOP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module im_reader #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    im_reader_if.master       bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_index;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_done;

    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic              r_fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_start_ok;
    logic              w_zero_len;
    logic              w_credit;
    logic              w_issue;
    logic              w_final_idx;
    logic              w_frame_end;
    logic              w_session_end;
    logic              w_push;
    logic              w_pop;
    logic              w_drained;

    assign w_start_ok  = (r_state == S_IDLE) && start;
    assign w_zero_len  = (length == '0);
    // Credit counts buffered words plus the word currently on mem_q.
    assign w_credit    = (r_count + CNT_W'(r_inflight)) < CNT_W'(FIFO_DEPTH);
    assign w_issue     = (r_state == S_RUN) && w_credit;
    assign w_final_idx = ({1'b0, r_index} == (r_len - LEN_W'(1)));
    assign w_frame_end = w_issue && w_final_idx;
    assign w_push      = r_inflight;
    assign w_pop       = bus.out_valid && bus.out_ready;
    // Nothing is issued in DRAIN, so the last word pushed is the final one.
    assign w_drained   = (r_state == S_DRAIN) && w_pop && bus.out_last &&
                         (r_count == CNT_W'(1)) && !r_inflight;

`ifdef IM_READER_LOOP_EN
    logic r_stop_seen;

    always_ff @(posedge clk) begin
        if (reset || (r_state == S_IDLE)) begin
            r_stop_seen <= 1'b0;
        end else if (stop) begin
            r_stop_seen <= 1'b1;
        end
    end

    assign w_session_end = stop || r_stop_seen;
`else
    logic w_unused_stop;
    assign w_unused_stop = stop;
    assign w_session_end = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start && !w_zero_len)          w_state_nxt = S_RUN;
            S_RUN:   if (w_frame_end && w_session_end) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drained)                     w_state_nxt = S_IDLE;
            default:                                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_base          <= '0;
            r_len           <= '0;
            r_index         <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_inflight      <= w_issue;
            r_inflight_last <= w_frame_end;
            r_done          <= (w_start_ok && w_zero_len) || w_drained;
            if (w_start_ok && !w_zero_len) begin
                r_base  <= base_addr;
                r_len   <= length;
                r_index <= '0;
            end else if (w_issue) begin
                r_index <= w_final_idx ? '0 : r_index + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= bus.mem_q;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;
    assign bus.mem_rden    = w_issue;
    assign bus.mem_address = r_base + r_index;
    assign bus.out_valid   = (r_count != '0);
    assign bus.out_data    = r_fifo_data[r_rd_ptr];
    assign bus.out_last    = r_fifo_last[r_rd_ptr];
endmodule
`default_nettype wire

// File: tb/tb_im_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_reader
// Description : Self-checking bench for im_reader; address/stream scoreboard
//               fed by a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_reader;
    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
`ifdef IM_READER_LOOP_EN
    localparam logic STOP_IDLE = 1'b1;
`else
    localparam logic STOP_IDLE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop = STOP_IDLE;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic              busy;
    logic              done;

    im_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    im_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          words_seen = 0;
    int          reads_seen = 0;
    int          outstanding = 0;
    int          max_out = 0;
    int          ready_mode = 0;
    int          phase = 0;
    logic [31:0] seed;
    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W:0]   exp_word [$];

    function automatic logic [31:0] word(input logic [ADDR_W-1:0] a);
        logic [31:0] x;
        x = {17'd0, a};
        return (x * 32'h9E37_79B1) ^ seed;
    endfunction

    // Reference: each frame reads base..base+len-1 modulo 2^15, last on final word.
    task automatic model_load(input logic [ADDR_W-1:0] b, input int len, input int frames);
        logic [ADDR_W-1:0] a;
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < len; i++) begin
                a = b + ADDR_W'(i);
                exp_addr.push_back(a);
                exp_word.push_back({(i == len - 1), word(a)});
            end
        end
    endtask

    // Image memory: one-cycle read latency, junk when not reading.
    always @(posedge clk) begin
        bus.mem_q <= bus.mem_rden ? word(bus.mem_address) : $urandom();
    end

    always @(posedge clk) begin
        #2;
        if (ready_mode != 3) begin
            phase = (phase + 1) % 3;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (phase == 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic              prev_stall = 1'b0;
    logic [DATA_W:0]   prev_word = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall  = 1'b0;
            outstanding = 0;
        end else begin
            if (bus.mem_rden) begin
                checks++;
                reads_seen++;
                outstanding++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL mem_addr: unexpected read of %h, none required", bus.mem_address);
                end else begin
                    if (bus.mem_address !== exp_addr[0]) begin
                        errors++;
                        $display("FAIL mem_addr: got %h required %h", bus.mem_address, exp_addr[0]);
                    end
                    void'(exp_addr.pop_front());
                end
            end
            if (prev_stall) begin
                checks++;
                if (!bus.out_valid || {bus.out_last, bus.out_data} !== prev_word) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b %h required v=1 %h", bus.out_valid,
                             {bus.out_last, bus.out_data}, prev_word);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                words_seen++;
                outstanding--;
                if (exp_word.size() == 0) begin
                    errors++;
                    $display("FAIL stream: unexpected word %h, none required", {bus.out_last, bus.out_data});
                end else begin
                    if ({bus.out_last, bus.out_data} !== exp_word[0]) begin
                        errors++;
                        $display("FAIL stream: got %h required %h", {bus.out_last, bus.out_data}, exp_word[0]);
                    end
                    void'(exp_word.pop_front());
                end
            end
            if (outstanding > max_out) max_out = outstanding;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = {bus.out_last, bus.out_data};
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = l;
        @(posedge clk); #1;
        start = 1'b0; base_addr = ADDR_W'($urandom()); length = (ADDR_W+1)'($urandom());
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, bus.mem_rden, bus.out_valid, bus.out_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000",
                     {busy, done, bus.mem_rden, bus.out_valid, bus.out_last});
        end
        checks++;
        if (bus.mem_address !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h required 0", bus.mem_address);
        end
        checks++;
        if (bus.out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", bus.out_data);
        end
    endtask

    task automatic test_basic();
        int cyc_valid = -1;
        int cyc_done  = -1;
        int w0 = words_seen;
        ready_mode = 0;
        model_load(15'h0010, 8, 1);
        do_start(15'h0010, 16'd8);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (cyc_valid < 0 && bus.out_valid) cyc_valid = k;
            if (done) begin
                cyc_done = k;
                break;
            end
        end
        checks++;
        if (cyc_valid != 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 3", cyc_valid);
        end
        checks++;
        if (cyc_done != 11) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d required 11", cyc_done);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: got %b required 0", busy);
        end
        checks++;
        if (words_seen - w0 != 8) begin
            errors++;
            $display("FAIL basic_count: got %0d required 8", words_seen - w0);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got %b required 0", done);
        end
    endtask

    task automatic test_transfer(input string name, input logic [ADDR_W-1:0] b,
                                 input int len, input int mode);
        int cyc;
        int w0 = words_seen;
        ready_mode = mode;
        model_load(b, len, 1);
        do_start(b, (ADDR_W+1)'(len));
        wait_done(40 * len + 40, cyc);
        checks++;
        if (cyc < 0 || words_seen - w0 != len || exp_word.size() != 0) begin
            errors++;
            $display("FAIL %s: done=%0d words %0d required %0d", name, cyc, words_seen - w0, len);
        end
    endtask

    task automatic test_stall();
        max_out = 0;
        test_transfer("stall_1in3", ADDR_W'($urandom()), 16, 1);
        checks++;
        if (max_out > FIFO_DEPTH || max_out < 1) begin
            errors++;
            $display("FAIL stall_fill: got %0d required 1..%0d", max_out, FIFO_DEPTH);
        end
    endtask

    task automatic test_zero_len();
        int r0 = reads_seen;
        int busy_seen = 0;
        ready_mode = 0;
        do_start(ADDR_W'($urandom()), '0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: got done=%b busy=%b required done=1 busy=0", done, busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || reads_seen != r0) begin
            errors++;
            $display("FAIL zero_quiet: got %0d busy/done cycles %0d reads required 0 0",
                     busy_seen, reads_seen - r0);
        end
    endtask

    task automatic test_start_busy();
        int cyc;
        int w0 = words_seen;
        int extra = 0;
        logic [ADDR_W-1:0] b = ADDR_W'($urandom());
        ready_mode = 2;
        model_load(b, 20, 1);
        do_start(b, 16'd20);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; base_addr = b + 15'h0100; length = 16'd5;
        @(posedge clk); #1 start = 1'b0;
        wait_done(400, cyc);
        checks++;
        if (cyc < 0 || words_seen - w0 != 20) begin
            errors++;
            $display("FAIL start_busy: done=%0d words %0d required 20", cyc, words_seen - w0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL start_busy_tail: got %0d busy cycles required 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int vcount = 0;
        logic [ADDR_W-1:0] b = ADDR_W'($urandom());
        ready_mode = 3;
        bus.out_ready = 1'b0;
        model_load(b, 16, 1);
        do_start(b, 16'd16);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (bus.mem_rden !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_credit: got rden=%b valid=%b required 0 1", bus.mem_rden, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.mem_rden !== 1'b1) begin
            errors++;
            $display("FAIL credit_resume: got rden=%b required 1", bus.mem_rden);
        end
        reset = 1'b1;
        exp_addr.delete();
        exp_word.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b busy=%b required 0 0", bus.out_valid, busy);
        end
        ready_mode = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) vcount++;
        end
        checks++;
        if (vcount != 0) begin
            errors++;
            $display("FAIL reset_discard: got %0d valid cycles required 0", vcount);
        end
        test_transfer("after_reset", ADDR_W'($urandom()), 9, 0);
    endtask

`ifdef IM_READER_LOOP_EN
    task automatic test_loop();
        int cyc;
        int w0 = words_seen;
        logic [ADDR_W-1:0] b = ADDR_W'($urandom());
        ready_mode = 0;
        stop = 1'b0;
        model_load(b, 3, 2);
        do_start(b, 16'd3);
        repeat (4) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_done(60, cyc);
        stop = STOP_IDLE;
        checks++;
        if (cyc < 0 || words_seen - w0 != 6 || exp_word.size() != 0) begin
            errors++;
            $display("FAIL loop_stop: done=%0d words %0d required 6", cyc, words_seen - w0);
        end
    endtask
`endif

    initial begin
        seed = $urandom();
        bus.out_ready = 1'b1;
        bus.mem_q = '0;
        test_reset();
        test_basic();
        test_transfer("wrap", 15'h7FFE, 4, 2);
        test_stall();
        test_zero_len();
        test_start_busy();
        test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            test_transfer("random", ADDR_W'($urandom()), int'($urandom_range(1, 40)), 2);
        end
`ifdef IM_READER_LOOP_EN
        test_loop();
`endif
        checks++;
        if (exp_addr.size() != 0 || exp_word.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d addr %0d words required 0 0", exp_addr.size(), exp_word.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
